// File: rtl/cache_mem_arbiter_pkg.sv
// Shared encodings for the cache/memory arbiter: FSM state codes and the line-base mask.
package cache_mem_arbiter_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FILL_I = 2'd1;
   localparam logic [1:0] ST_FILL_D = 2'd2;
   localparam logic [1:0] ST_WRITE  = 2'd3;

   // A line is 8 words of 16 bits = 16 bytes, so the low nibble selects within the line.
   localparam logic [15:0] LINE_MASK = 16'hFFF0;

endpackage

// File: rtl/cache_mem_arbiter_line_addr_gen.sv
// Line fill address generator: latches the line base on a grant and walks the
// read address through the line, one word per cycle, until every word is issued.
module line_addr_gen
   import cache_mem_arbiter_pkg::*;
#(
   parameter int LINE_WORDS = 8,
   parameter int ADDR_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] miss_addr,
   input  logic              active,
   output logic              issue_en,
   output logic [ADDR_W-1:0] issue_addr
);

   localparam int CNT_W = $clog2(LINE_WORDS) + 1;
   // Ones above the in-line offset bits regardless of ADDR_W.
   localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(~LINE_MASK);

   logic [CNT_W-1:0]  issue_cnt;
   logic [ADDR_W-1:0] base;

   assign issue_en   = active && (issue_cnt < CNT_W'(LINE_WORDS));
   assign issue_addr = base + (ADDR_W'(issue_cnt) << 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt <= '0;
      end else if (load) begin
         issue_cnt <= '0;
      end else if (issue_en) begin
         issue_cnt <= issue_cnt + CNT_W'(1);
      end
   end

   // Base is pure data and is only observed while a fill is issuing.
   always_ff @(posedge clk) begin
      if (load) begin
         base <= miss_addr & BASE_MASK;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shared memory port arbiter for an I-cache and a write-through D-cache:
// D stores first, then line fills with round-robin between contending misses.
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int LINE_WORDS = 8,
   parameter int ADDR_W     = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_miss,
   input  logic [ADDR_W-1:0]             i_miss_addr,
   input  logic                          d_miss,
   input  logic [ADDR_W-1:0]             d_miss_addr,
   input  logic                          d_wr_req,
   input  logic [ADDR_W-1:0]             d_wr_addr,
   input  logic [ADDR_W-1:0]             d_wr_data,
   input  logic                          mem_data_valid,
   output logic                          mem_enable,
   output logic                          mem_wr,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [ADDR_W-1:0]             mem_wdata,
   output logic                          i_busy,
   output logic                          d_busy,
   output logic                          i_data_we,
   output logic                          d_data_we,
   output logic                          i_tag_we,
   output logic                          d_tag_we,
   output logic                          d_wr_ack,
   output logic [$clog2(LINE_WORDS)-1:0] i_word_sel,
   output logic [$clog2(LINE_WORDS)-1:0] d_word_sel
);

   localparam int CNT_W = $clog2(LINE_WORDS) + 1;
   localparam int SEL_W = $clog2(LINE_WORDS);
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [CNT_W-1:0]  ret_cnt;
   logic              rr_favor_d;
   logic              rr_update;
   logic              grant_load;
   logic [ADDR_W-1:0] grant_addr;
   logic              in_fill;
   logic              ret_en;
   logic              line_done;
   logic              issue_en;
   logic [ADDR_W-1:0] issue_addr;

   assign in_fill   = (state == ST_FILL_I) || (state == ST_FILL_D);
   assign ret_en    = in_fill && mem_data_valid && (ret_cnt < CNT_W'(LINE_WORDS));
   assign line_done = ret_en && (ret_cnt == LAST_WORD);

   line_addr_gen #(
      .LINE_WORDS (LINE_WORDS),
      .ADDR_W     (ADDR_W)
   ) u_line_addr_gen (
      .clk        (clk),
      .rst        (rst_n),
      .load       (grant_load),
      .miss_addr  (grant_addr),
      .active     (in_fill),
      .issue_en   (issue_en),
      .issue_addr (issue_addr)
   );

   // The round-robin bit only moves when both misses actually contend, so an
   // uncontended fill never steals the other side's next turn.
   always_comb begin
      state_nxt  = state;
      grant_load = 1'b0;
      grant_addr = d_miss_addr;
      rr_update  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (d_wr_req) begin
               state_nxt = ST_WRITE;
            end else if (i_miss && d_miss) begin
               grant_load = 1'b1;
               rr_update  = 1'b1;
               if (rr_favor_d) begin
                  state_nxt  = ST_FILL_D;
                  grant_addr = d_miss_addr;
               end else begin
                  state_nxt  = ST_FILL_I;
                  grant_addr = i_miss_addr;
               end
            end else if (d_miss) begin
               grant_load = 1'b1;
               state_nxt  = ST_FILL_D;
               grant_addr = d_miss_addr;
            end else if (i_miss) begin
               grant_load = 1'b1;
               state_nxt  = ST_FILL_I;
               grant_addr = i_miss_addr;
            end
         end
         ST_FILL_I, ST_FILL_D: begin
            if (line_done) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state      <= ST_IDLE;
         ret_cnt    <= '0;
         rr_favor_d <= 1'b1;
      end else begin
         state <= state_nxt;
         if (grant_load) begin
            ret_cnt <= '0;
         end else if (ret_en) begin
            ret_cnt <= ret_cnt + CNT_W'(1);
         end
         if (rr_update) begin
            rr_favor_d <= ~rr_favor_d;
         end
      end
   end

   always_comb begin
      mem_enable = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      d_wr_ack   = 1'b0;
      if (state == ST_WRITE) begin
         mem_enable = 1'b1;
         mem_wr     = 1'b1;
         mem_addr   = d_wr_addr;
         mem_wdata  = d_wr_data;
         d_wr_ack   = 1'b1;
      end else if (issue_en) begin
         mem_enable = 1'b1;
         mem_addr   = issue_addr;
      end
   end

   assign i_data_we  = ret_en && (state == ST_FILL_I);
   assign d_data_we  = ret_en && (state == ST_FILL_D);
   assign i_tag_we   = line_done && (state == ST_FILL_I);
   assign d_tag_we   = line_done && (state == ST_FILL_D);
   assign i_word_sel = i_data_we ? ret_cnt[SEL_W-1:0] : '0;
   assign d_word_sel = d_data_we ? ret_cnt[SEL_W-1:0] : '0;

   // Busy follows the raw requests, so it is masked while reset is held.
   assign i_busy = ~rst_n & (i_miss | (state == ST_FILL_I));
   assign d_busy = ~rst_n & (d_miss | d_wr_req | (state == ST_FILL_D) | (state == ST_WRITE));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized bench for cache_mem_arbiter against a transaction-level model of
// grants, line address sequences and word returns, with a latency memory model.
module tb_cache_mem_arbiter;

   localparam int LW = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_miss, d_miss, d_wr_req;
   logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
   logic        mem_data_valid = 1'b0;
   logic        mem_enable, mem_wr;
   logic [15:0] mem_addr, mem_wdata;
   logic        i_busy, d_busy, i_data_we, d_data_we, i_tag_we, d_tag_we, d_wr_ack;
   logic [2:0]  i_word_sel, d_word_sel;

   always #5 clk = ~clk;

   cache_mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_miss(i_miss), .i_miss_addr(i_miss_addr),
      .d_miss(d_miss), .d_miss_addr(d_miss_addr),
      .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
      .mem_data_valid(mem_data_valid),
      .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .i_busy(i_busy), .d_busy(d_busy), .i_data_we(i_data_we), .d_data_we(d_data_we),
      .i_tag_we(i_tag_we), .d_tag_we(d_tag_we), .d_wr_ack(d_wr_ack),
      .i_word_sel(i_word_sel), .d_word_sel(d_word_sel)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] outs_vec();
      return {17'd0, mem_enable, mem_wr, mem_addr, mem_wdata, i_busy, d_busy,
              i_data_we, d_data_we, i_tag_we, d_tag_we, d_wr_ack, i_word_sel, d_word_sel};
   endfunction

   // Memory: each read command returns one valid mem_lat edges later, in order.
   int cyc      = 0;
   int mem_lat  = 4;
   bit spur_req = 1'b0;
   int due_q[$];
   int last_due = 0;

   initial begin : mem_model
      int d;
      forever begin
         @(posedge clk or posedge rst_n);
         if (rst_n) begin
            due_q.delete();
            last_due = 0;
            mem_data_valid <= 1'b0;
         end else begin
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
               void'(due_q.pop_front());
               mem_data_valid <= 1'b1;
            end else begin
               mem_data_valid <= spur_req;
            end
            if (mem_enable && !mem_wr) begin
               d = cyc + mem_lat;
               if (d <= last_due) d = last_due + 1;
               due_q.push_back(d);
               last_due = d;
            end
         end
         cyc++;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Model of the arbitration history: the next contended grant goes to D when set.
   bit fav_d = 1'b1;

   // Serve the transaction the DUT should pick from IDLE; returns with DUT back in IDLE.
   task automatic serve_one(input int abort_after, input int drop_at);
      int          kind;
      logic [15:0] base;
      int          n_iss, n_ret, budget;
      if (d_wr_req) kind = 0;
      else if (i_miss && d_miss) begin
         kind  = fav_d ? 2 : 1;
         fav_d = !fav_d;
      end
      else if (d_miss) kind = 2;
      else if (i_miss) kind = 1;
      else return;
      @(posedge clk); @(negedge clk);
      if (kind == 0) begin
         check_eq("wr_en",   mem_enable, 1);
         check_eq("wr_wr",   mem_wr, 1);
         check_eq("wr_addr", mem_addr, d_wr_addr);
         check_eq("wr_data", mem_wdata, d_wr_data);
         check_eq("wr_ack",  d_wr_ack, 1);
         check_eq("wr_dbusy", d_busy, 1);
         d_wr_req = 1'b0;
         @(posedge clk); @(negedge clk);
         check_eq("wr_ack_off", d_wr_ack, 0);
         check_eq("wr_en_off",  mem_enable, 0);
         return;
      end
      base   = (kind == 1 ? i_miss_addr : d_miss_addr) & 16'hFFF0;
      n_iss  = 0;
      n_ret  = 0;
      budget = 0;
      while (n_ret < LW) begin
         if (n_iss < LW) begin
            check_eq("fill_en",   mem_enable, 1);
            check_eq("fill_rd",   mem_wr, 0);
            check_eq("fill_addr", mem_addr, base + 16'(2 * n_iss));
            n_iss++;
         end else begin
            check_eq("fill_en_off", mem_enable, 0);
         end
         check_eq("busy_i", i_busy, (kind == 1) ? 1'b1 : i_miss);
         check_eq("busy_d", d_busy, (kind == 2) ? 1'b1 : (d_miss | d_wr_req));
         if (mem_data_valid) begin
            check_eq("we_grant",  (kind == 1) ? i_data_we : d_data_we, 1);
            check_eq("we_other",  (kind == 1) ? d_data_we : i_data_we, 0);
            check_eq("sel_grant", (kind == 1) ? i_word_sel : d_word_sel, n_ret);
            check_eq("sel_other", (kind == 1) ? d_word_sel : i_word_sel, 0);
            check_eq("tag_grant", (kind == 1) ? i_tag_we : d_tag_we, n_ret == LW - 1);
            check_eq("tag_other", (kind == 1) ? d_tag_we : i_tag_we, 0);
            n_ret++;
         end else begin
            check_eq("we_quiet", {i_data_we, d_data_we, i_tag_we, d_tag_we}, 0);
         end
         if (abort_after > 0 && n_ret == abort_after) begin
            rst_n = 1'b1;
            #1;
            check_eq("rst_outs_now", outs_vec(), 0);
            fav_d = 1'b1;
            @(posedge clk); #1;
            check_eq("rst_outs_hold", outs_vec(), 0);
            @(negedge clk);
            rst_n = 1'b0;
            return;
         end
         if ((drop_at > 0 && n_ret == drop_at) || n_ret == LW) begin
            if (kind == 1) i_miss = 1'b0;
            else d_miss = 1'b0;
         end
         @(posedge clk); @(negedge clk);
         budget++;
         if (budget > 200) begin
            check_eq("fill_timeout", n_ret, LW);
            return;
         end
      end
      check_eq("idle_en", mem_enable, 0);
   endtask

   task automatic serve_all(input int abort_after, input int drop_at);
      int guard = 0;
      int ab = abort_after;
      int dr = drop_at;
      while ((i_miss || d_miss || d_wr_req) && guard < 20) begin
         serve_one(ab, dr);
         ab = 0;
         guard++;
      end
      check_eq("serve_bound", guard < 20, 1);
   endtask

   task automatic spurious_valid();
      spur_req = 1'b1;
      @(posedge clk); @(negedge clk);
      spur_req = 1'b0;
      check_eq("spur_valid_seen", mem_data_valid, 1);
      check_eq("spur_no_we", {i_data_we, d_data_we, i_tag_we, d_tag_we}, 0);
      check_eq("spur_no_sel", {i_word_sel, d_word_sel}, 0);
      @(posedge clk); @(negedge clk);
   endtask

   initial begin : main
      int ab, dr;
      rst_n = 1'b1;
      i_miss = 1'b1; d_miss = 1'b0; d_wr_req = 1'b1;
      i_miss_addr = 16'h0; d_miss_addr = 16'h0; d_wr_addr = 16'hA5A5; d_wr_data = 16'h5A5A;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset_outs", outs_vec(), 0);
      i_miss = 1'b0; d_wr_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("idle_outs", outs_vec(), 0);

      // Single D fill from 0x1234, latency 4.
      mem_lat = 4;
      d_miss = 1'b1; d_miss_addr = 16'h1234;
      serve_all(0, 0);

      // Contention right after reset: D then I; second pair: I first.
      i_miss = 1'b1; i_miss_addr = 16'h2468;
      d_miss = 1'b1; d_miss_addr = 16'h8ACE;
      serve_all(0, 0);
      mem_lat = 2;
      i_miss = 1'b1; i_miss_addr = 16'h1357;
      d_miss = 1'b1; d_miss_addr = 16'h9BDF;
      serve_all(0, 0);

      // Store beats a miss.
      d_wr_req = 1'b1; d_wr_addr = 16'hBEEF; d_wr_data = 16'hCAFE;
      i_miss = 1'b1; i_miss_addr = 16'h4000;
      serve_all(0, 0);

      spurious_valid();

      // Reset after the third returned word, then a clean fill.
      mem_lat = 3;
      i_miss = 1'b1; i_miss_addr = 16'h7777;
      serve_all(3, 0);

      // Requester drops mid-fill; line still completes.
      mem_lat = 1;
      i_miss = 1'b1; i_miss_addr = 16'h0F0F;
      serve_all(0, 4);

      for (int it = 0; it < 40; it++) begin
         mem_lat     = $urandom_range(1, 6);
         i_miss      = 1'($urandom_range(0, 1));
         d_miss      = 1'($urandom_range(0, 1));
         d_wr_req    = ($urandom_range(0, 3) == 0);
         i_miss_addr = 16'($urandom);
         d_miss_addr = 16'($urandom);
         d_wr_addr   = 16'($urandom);
         d_wr_data   = 16'($urandom);
         ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : 0;
         dr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
         if (!(i_miss || d_miss || d_wr_req)) spurious_valid();
         else serve_all(ab, dr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_WORDS, default 8, giving the 16-bit words per cache line.
REQ-002 The block SHALL have parameter ADDR_W, default 16, giving the address and data width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-high (asserted = 1).
REQ-005 The block SHALL have ports i_miss (input, 1 bit) and i_miss_addr (input, 16 bits): I-cache fill request and its miss address.
REQ-006 The block SHALL have ports d_miss (input, 1 bit) and d_miss_addr (input, 16 bits): D-cache fill request and its miss address.
REQ-007 The block SHALL have ports d_wr_req (input, 1 bit), d_wr_addr (input, 16 bits) and d_wr_data (input, 16 bits): D-cache write-through store.
REQ-008 The block SHALL have port mem_data_valid, input, 1 bit: memory read data is returning this cycle.
REQ-009 The block SHALL have ports mem_enable, mem_wr, mem_addr[15:0] and mem_wdata[15:0], all outputs: the memory command.
REQ-010 The block SHALL have outputs i_busy, d_busy, i_data_we, d_data_we, i_tag_we, d_tag_we and d_wr_ack, 1 bit each.
REQ-011 The block SHALL have outputs i_word_sel[2:0] and d_word_sel[2:0]: index of the line word being returned.

Function
REQ-012 The block SHALL implement states IDLE, FILL_I, FILL_D and WRITE.
REQ-013 In IDLE, a pending d_wr_req SHALL win over any miss: go to WRITE.
REQ-014 In IDLE, with only one miss pending, the block SHALL enter that requester's FILL state.
REQ-015 In IDLE, with both misses pending, the block SHALL grant the requester not granted last (round-robin bit); after reset that bit SHALL favour D.
REQ-016 On entering FILL, the block SHALL latch the line base address as miss_addr AND 16'hFFF0; the issue and return counters SHALL clear.
REQ-017 In FILL, the block SHALL assert mem_enable=1, mem_wr=0 and mem_addr=base+2*issue_cnt each cycle while issue_cnt<LINE_WORDS, then deassert mem_enable.
REQ-018 In FILL, each mem_data_valid SHALL pulse the granted requester's *_data_we for that cycle, with *_word_sel=ret_cnt, and SHALL increment ret_cnt.
REQ-019 On the cycle of the LINE_WORDS-th valid, the block SHALL also pulse the granted *_tag_we, then return to IDLE on the next edge.
REQ-020 Issue and return SHALL proceed concurrently; a valid arriving in the same cycle as an issue SHALL be counted.
REQ-021 mem_data_valid in IDLE or WRITE SHALL be ignored: no *_data_we.
REQ-022 In WRITE, for one cycle, the block SHALL drive mem_enable=1, mem_wr=1, mem_addr=d_wr_addr and mem_wdata=d_wr_data, pulse d_wr_ack, then return to IDLE.
REQ-023 i_busy SHALL equal i_miss OR (state==FILL_I); d_busy SHALL equal d_miss OR d_wr_req OR (state==FILL_D or WRITE).
REQ-024 Request deassertion during FILL SHALL NOT abort the fill; the line SHALL complete.
REQ-025 Outside their states, mem_addr, mem_wdata and the word_sel outputs SHALL be 0.
REQ-026 Counter widths SHALL be clog2(LINE_WORDS)+1 bits, with no wrap inside a fill.

Reset
REQ-027 While rst_n=1 the block SHALL immediately force state IDLE, counters 0, the round-robin bit to favour D, and every output to 0.
REQ-028 Reset mid-fill SHALL abandon the line with no *_tag_we; the memory model SHALL be reset by the same signal.

Structure
REQ-029 State encodings (2 bits) and the LINE_MASK constant 16'hFFF0 SHALL live in a shared cache package.
REQ-030 One sub-module, line_addr_gen (base latch, issue counter and address adder), SHALL be instantiated; the FSM, return counter and arbitration SHALL be in the top.

Verification
REQ-031 Scenario: d_miss with addr 0x1234 and memory latency 4 -> mem_addr sequence 0x1230, 0x1232 … 0x123E; 8 d_data_we pulses with d_word_sel 0..7; d_tag_we on the 8th pulse.
REQ-032 Scenario: i_miss and d_miss asserted together after reset -> FILL_D first, then FILL_I; on a second simultaneous pair, I is served first.
REQ-033 Scenario: d_wr_req and i_miss asserted together -> one WRITE cycle (mem_wr=1, d_wr_ack=1), then FILL_I.
REQ-034 Scenario: rst_n pulsed after the 3rd valid of a fill -> all outputs 0 at once; no tag_we; a following fill completes normally.
REQ-035 Scenario: spurious mem_data_valid in IDLE -> no *_data_we; ret_cnt stays 0.
REQ-036 Scenario: i_miss dropped mid-fill -> all 8 words still returned, with i_tag_we.
